mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch path and the load/store path of the multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller. Each requester uses a req/ack handshake. The block latches the winning request, drives one memory transaction, and returns read data and ack to the winner. Arbitration is round-robin on simultaneous requests.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// State and grant encodings plus default bus widths.
package mem_arb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ADDR_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    FETCH,
    DATA
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// slave = arbiter view, master = requesters and memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [XLEN-1:0]   if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_be;
  logic              d_ack;
  logic [XLEN-1:0]   d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Optional wait-cycle abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = XLEN / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;

  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [XLEN-1:0]   mwdata_q, mwdata_d;
  logic [BE_W-1:0]   mbe_q, mbe_d;

  logic              iack_q, iack_d;
  logic [XLEN-1:0]   irdata_q, irdata_d;
  logic              ierr_q, ierr_d;
  logic              dack_q, dack_d;
  logic [XLEN-1:0]   drdata_q, drdata_d;
  logic              derr_q, derr_d;

  logic busy;
  logic done;
  logic tmo;
  logic pick_i;
  logic pick_d;

  assign busy   = (state_q == BUSY_I)
               || (state_q == BUSY_D);
  assign done   = busy && bus.mem_ready;
  assign pick_i = bus.if_req
               && (!bus.d_req || last_q == DATA);
  assign pick_d = bus.d_req && !pick_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // mem_ready on the limit cycle completes normally
  assign tmo = busy && !bus.mem_ready
            && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (busy && !bus.mem_ready && !tmo) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    iack_d   = 1'b0;
    irdata_d = '0;
    ierr_d   = 1'b0;
    dack_d   = 1'b0;
    drdata_d = '0;
    derr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_i: begin
            state_d  = BUSY_I;
            last_d   = FETCH;
            mreq_d   = 1'b1;
            mwe_d    = 1'b0;
            maddr_d  = bus.if_addr;
            mwdata_d = '0;
            mbe_d    = '1;
          end
          pick_d: begin
            state_d  = BUSY_D;
            last_d   = DATA;
            mreq_d   = 1'b1;
            mwe_d    = bus.d_we;
            maddr_d  = bus.d_addr;
            mwdata_d = bus.d_wdata;
            mbe_d    = bus.d_be;
          end
          default: ;
        endcase
      end
      BUSY_I, BUSY_D: begin
        if (done || tmo) begin
          state_d  = RESP;
          mreq_d   = 1'b0;
          mwe_d    = 1'b0;
          maddr_d  = '0;
          mwdata_d = '0;
          mbe_d    = '0;
          if (state_q == BUSY_I) begin
            iack_d   = 1'b1;
            ierr_d   = tmo;
            irdata_d = done ? bus.mem_rdata : '0;
          end else begin
            dack_d   = 1'b1;
            derr_d   = tmo;
            drdata_d = (done && !mwe_q)
                     ? bus.mem_rdata : '0;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= DATA;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      iack_q   <= 1'b0;
      irdata_q <= '0;
      ierr_q   <= 1'b0;
      dack_q   <= 1'b0;
      drdata_q <= '0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      iack_q   <= iack_d;
      irdata_q <= irdata_d;
      ierr_q   <= ierr_d;
      dack_q   <= dack_d;
      drdata_q <= drdata_d;
      derr_q   <= derr_d;
    end
  end

  assign bus.mem_req   = mreq_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_be    = mbe_q;
  assign bus.if_ack    = iack_q;
  assign bus.if_rdata  = irdata_q;
  assign bus.if_err    = ierr_q;
  assign bus.d_ack     = dack_q;
  assign bus.d_rdata   = drdata_q;
  assign bus.d_err     = derr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
// Timeout steps run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_port_arbiter_if #(.XLEN(32), .ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .XLEN(32),
    .ADDR_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #10 rst = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    idle_inputs();
    #3;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    chk("rst_if_ack", 32'(bus.if_ack), 0);
    chk("rst_d_ack", 32'(bus.d_ack), 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    #10 rst = 1'b1;
    tick();

    // fetch only, zero-wait memory
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h13;
    tick();
    chk("f_mem_req", 32'(bus.mem_req), 1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_be", 32'(bus.mem_be), 32'hF);
    chk("f_mem_we", 32'(bus.mem_we), 0);
    chk("f_ack_early", 32'(bus.if_ack), 0);
    tick();
    chk("f_if_ack", 32'(bus.if_ack), 1);
    chk("f_if_rdata", bus.if_rdata, 32'h13);
    chk("f_if_err", 32'(bus.if_err), 0);
    chk("f_d_ack", 32'(bus.d_ack), 0);
    chk("f_resp_req", 32'(bus.mem_req), 0);
    bus.if_req = 1'b0;
    tick();
    chk("f_ack_drop", 32'(bus.if_ack), 0);
    chk("f_rdata_clr", bus.if_rdata, 0);
    chk("f_d_never", 32'(bus.d_ack), 0);

    // store with three wait cycles
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hAAAA5555;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h2000;
    bus.d_wdata   = 32'hDEADBEEF;
    bus.d_be      = 4'h3;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("s_req_c%0d", c),
          32'(bus.mem_req), 1);
      chk($sformatf("s_we_c%0d", c),
          32'(bus.mem_we), 1);
      chk($sformatf("s_wdata_c%0d", c),
          bus.mem_wdata, 32'hDEADBEEF);
      chk($sformatf("s_be_c%0d", c),
          32'(bus.mem_be), 32'h3);
      chk($sformatf("s_addr_c%0d", c),
          bus.mem_addr, 32'h2000);
      chk($sformatf("s_ack_c%0d", c),
          32'(bus.d_ack), 0);
      if (c == 2) bus.d_wdata = 32'h0;
      if (c == 4) bus.mem_ready = 1'b1;
    end
    tick();
    chk("s_d_ack", 32'(bus.d_ack), 1);
    chk("s_d_rdata", bus.d_rdata, 0);
    chk("s_d_err", 32'(bus.d_err), 0);
    chk("s_if_ack", 32'(bus.if_ack), 0);
    idle_inputs();
    tick();
    chk("s_ack_drop", 32'(bus.d_ack), 0);

    // simultaneous requests after reset alternate
    do_reset();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h40;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h80;
    bus.d_be      = 4'hF;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rdata = 32'h11 + 32'(k);
      tick();
      chk($sformatf("rr_addr_%0d", k), bus.mem_addr,
          (k % 2 == 0) ? 32'h40 : 32'h80);
      tick();
      chk($sformatf("rr_iack_%0d", k),
          32'(bus.if_ack), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_dack_%0d", k),
          32'(bus.d_ack), (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0)
        chk($sformatf("rr_irdata_%0d", k),
            bus.if_rdata, 32'h11 + 32'(k));
      else
        chk($sformatf("rr_drdata_%0d", k),
            bus.d_rdata, 32'h11 + 32'(k));
      if (k == 3) idle_inputs();
      tick();
      chk($sformatf("rr_gap_i_%0d", k),
          32'(bus.if_ack), 0);
      chk($sformatf("rr_gap_d_%0d", k),
          32'(bus.d_ack), 0);
    end
    tick();
    chk("rr_quiet", 32'(bus.mem_req), 0);

    // reset during BUSY_D drops the transaction
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h3000;
    bus.d_be   = 4'hF;
    tick();
    chk("r_busy", 32'(bus.mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("r_req_async", 32'(bus.mem_req), 0);
    chk("r_addr_async", bus.mem_addr, 0);
    chk("r_be_async", 32'(bus.mem_be), 0);
    chk("r_dack_async", 32'(bus.d_ack), 0);
    idle_inputs();
    bus.mem_ready = 1'b1;
    #10 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("r_noreq_%0d", c),
          32'(bus.mem_req), 0);
      chk($sformatf("r_nodack_%0d", c),
          32'(bus.d_ack), 0);
      chk($sformatf("r_noiack_%0d", c),
          32'(bus.if_ack), 0);
    end

    // fetch raised during data RESP waits for IDLE
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h4000;
    bus.mem_rdata = 32'h77;
    tick();
    chk("p_dbusy", bus.mem_addr, 32'h4000);
    tick();
    chk("p_dack", 32'(bus.d_ack), 1);
    chk("p_drdata", bus.d_rdata, 32'h77);
    bus.d_req     = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h300;
    bus.mem_rdata = 32'h99;
    tick();
    chk("p_idle_req", 32'(bus.mem_req), 0);
    chk("p_idle_ack", 32'(bus.if_ack), 0);
    tick();
    chk("p_busy_addr", bus.mem_addr, 32'h300);
    chk("p_busy_ack", 32'(bus.if_ack), 0);
    tick();
    chk("p_iack", 32'(bus.if_ack), 1);
    chk("p_irdata", bus.if_rdata, 32'h99);
    idle_inputs();
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // stuck memory aborts after eight BUSY cycles
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h500;
    bus.mem_rdata = 32'h55;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t_wait_%0d", c),
          32'(bus.if_ack), 0);
    end
    tick();
    chk("t_ack", 32'(bus.if_ack), 1);
    chk("t_err", 32'(bus.if_err), 1);
    chk("t_rdata", bus.if_rdata, 0);
    idle_inputs();
    tick();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h600;
    bus.mem_rdata = 32'h66;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) bus.mem_ready = 1'b1;
    end
    tick();
    chk("t_lim_ack", 32'(bus.if_ack), 1);
    chk("t_lim_err", 32'(bus.if_err), 0);
    chk("t_lim_rdata", bus.if_rdata, 32'h66);
    idle_inputs();
    tick();
`else
    chk("no_tmo_ierr", 32'(bus.if_err), 0);
    chk("no_tmo_derr", 32'(bus.d_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
